// File: rtl/tlk2711_rx_if.sv
// Receive word bus from the TLK2711 deserializer and the recovered data stream.
interface tlk2711_rx_if;
    logic [15:0] i_rxd;
    logic        i_rklsb;
    logic        i_rkmsb;
    logic [15:0] o_data;
    logic        o_data_valid;
    logic        o_sof;
    logic        o_eof;

    // master drives the received words and observes the recovered stream
    modport master (
        output i_rxd, i_rklsb, i_rkmsb,
        input  o_data, o_data_valid, o_sof, o_eof
    );

    modport slave (
        input  i_rxd, i_rklsb, i_rkmsb,
        output o_data, o_data_valid, o_sof, o_eof
    );
endinterface

// File: rtl/tlk2711_rx_checker.sv
// TLK2711 receive frame checker: recovers comma/SOF/counting-data frames,
// checks the data pattern and keeps lock, frame and error statistics.
module tlk2711_rx_checker #(
    parameter int unsigned DATA_LEN    = 32,
    parameter int unsigned LOCK_FRAMES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    tlk2711_rx_if.slave        rx,
    input  logic               i_clear,
    output logic               o_frame_err,
    output logic               o_lock,
    output logic [31:0]        o_frame_cnt,
    output logic [31:0]        o_err_cnt,
    output logic [31:0]        o_sync_err_cnt
);

    localparam int unsigned IDX_W = 5;
    localparam int unsigned LCK_W = 4;
    localparam int unsigned CNT_W = 32;
    localparam logic [15:0]      COMMA_WORD = 16'hC5BC;
    localparam logic [15:0]      SOF_WORD   = 16'hABBC;
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_LEN - 1);
    localparam logic [LCK_W-1:0] LOCK_TGT   = LCK_W'(LOCK_FRAMES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ferr_flag_q, ferr_flag_d;
    logic [LCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             lock_q, lock_d;
    logic [15:0]      data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             frame_err_q, frame_err_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] sync_err_cnt_q, sync_err_cnt_d;

    logic        is_comma_c, is_sof_c, is_data_c;
    logic [15:0] exp_word_c;
    logic        mismatch_c;
    logic        inc_frame_c, inc_err_c, inc_sync_c;

    // word classification of the current input
    assign is_comma_c = rx.i_rklsb && !rx.i_rkmsb && (rx.i_rxd == COMMA_WORD);
    assign is_sof_c   = rx.i_rklsb && !rx.i_rkmsb && (rx.i_rxd == SOF_WORD);
    assign is_data_c  = !rx.i_rklsb && !rx.i_rkmsb;
    assign exp_word_c = {3'b000, idx_q, 3'b000, idx_q};
    assign mismatch_c = (rx.i_rxd != exp_word_c);

    // saturating counter with clear taking priority over increment
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic clr);
        logic [CNT_W-1:0] res;
        res = cnt;
        if (clr) begin
            res = '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            res = cnt + CNT_W'(1);
        end
        return res;
    endfunction

    // next-state and output decode
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ferr_flag_d  = ferr_flag_q;
        lock_cnt_d   = lock_cnt_q;
        lock_d       = lock_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        frame_err_d  = 1'b0;
        inc_frame_c  = 1'b0;
        inc_err_c    = 1'b0;
        inc_sync_c   = 1'b0;

        unique case (state_q)
            ST_HUNT: begin
                if (is_comma_c) begin
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (is_comma_c) begin
                    state_d = ST_SYNC;
                end else if (is_sof_c) begin
                    state_d     = ST_DATA;
                    idx_d       = '0;
                    sof_d       = 1'b1;
                    ferr_flag_d = 1'b0;
                end else begin
                    state_d    = ST_HUNT;
                    inc_sync_c = 1'b1;
                end
            end
            ST_DATA: begin
                if (is_data_c) begin
                    data_d       = rx.i_rxd;
                    data_valid_d = 1'b1;
                    idx_d        = idx_q + IDX_W'(1);
                    if (mismatch_c) begin
                        inc_err_c   = 1'b1;
                        frame_err_d = 1'b1;
                        ferr_flag_d = 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        eof_d   = 1'b1;
                        state_d = ST_SYNC;
                        if (!ferr_flag_q && !mismatch_c) begin
                            inc_frame_c = 1'b1;
                            if (lock_cnt_q < LOCK_TGT) begin
                                lock_cnt_d = lock_cnt_q + LCK_W'(1);
                            end
                            if (lock_cnt_d >= LOCK_TGT) begin
                                lock_d = 1'b1;
                            end
                        end else begin
                            lock_cnt_d = '0;
                            lock_d     = 1'b0;
                        end
                    end
                end else if (is_comma_c) begin
                    state_d    = ST_SYNC;
                    inc_sync_c = 1'b1;
                end else if (is_sof_c) begin
                    // restart: the truncated frame is dropped, the new one begins
                    state_d     = ST_DATA;
                    idx_d       = '0;
                    sof_d       = 1'b1;
                    ferr_flag_d = 1'b0;
                    inc_sync_c  = 1'b1;
                end else begin
                    state_d    = ST_HUNT;
                    inc_sync_c = 1'b1;
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        if (inc_sync_c) begin
            frame_err_d = 1'b1;
            lock_cnt_d  = '0;
            lock_d      = 1'b0;
        end
        if (state_d == ST_HUNT) begin
            lock_cnt_d = '0;
            lock_d     = 1'b0;
        end

        frame_cnt_d    = cnt_next(frame_cnt_q, inc_frame_c, i_clear);
        err_cnt_d      = cnt_next(err_cnt_q, inc_err_c, i_clear);
        sync_err_cnt_d = cnt_next(sync_err_cnt_q, inc_sync_c, i_clear);
    end

    // state and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_HUNT;
            idx_q          <= '0;
            ferr_flag_q    <= 1'b0;
            lock_cnt_q     <= '0;
            lock_q         <= 1'b0;
            data_q         <= '0;
            data_valid_q   <= 1'b0;
            sof_q          <= 1'b0;
            eof_q          <= 1'b0;
            frame_err_q    <= 1'b0;
            frame_cnt_q    <= '0;
            err_cnt_q      <= '0;
            sync_err_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            ferr_flag_q    <= ferr_flag_d;
            lock_cnt_q     <= lock_cnt_d;
            lock_q         <= lock_d;
            data_q         <= data_d;
            data_valid_q   <= data_valid_d;
            sof_q          <= sof_d;
            eof_q          <= eof_d;
            frame_err_q    <= frame_err_d;
            frame_cnt_q    <= frame_cnt_d;
            err_cnt_q      <= err_cnt_d;
            sync_err_cnt_q <= sync_err_cnt_d;
        end
    end

    assign rx.o_data       = data_q;
    assign rx.o_data_valid = data_valid_q;
    assign rx.o_sof        = sof_q;
    assign rx.o_eof        = eof_q;
    assign o_frame_err     = frame_err_q;
    assign o_lock          = lock_q;
    assign o_frame_cnt     = frame_cnt_q;
    assign o_err_cnt       = err_cnt_q;
    assign o_sync_err_cnt  = sync_err_cnt_q;

endmodule

// File: tb/tb_tlk2711_rx_checker.sv
// Directed bench for tlk2711_rx_checker: a vector table for word-class corners
// plus hand-written frame sequences for lock, corruption, truncation and reset.
module tb_tlk2711_rx_checker;

    localparam int DL = 32;
    localparam logic [15:0] C_W = 16'hC5BC;
    localparam logic [15:0] S_W = 16'hABBC;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        frame_err;
    logic        lock;
    logic [31:0] frame_cnt;
    logic [31:0] err_cnt;
    logic [31:0] sync_cnt;

    int checks = 0;
    int errors = 0;
    int nvalid = 0;

    tlk2711_rx_if rx_if ();

    tlk2711_rx_checker dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rx             (rx_if),
        .i_clear        (clear),
        .o_frame_err    (frame_err),
        .o_lock         (lock),
        .o_frame_cnt    (frame_cnt),
        .o_err_cnt      (err_cnt),
        .o_sync_err_cnt (sync_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rxd;
        logic        kl;
        logic        km;
        logic        clr;
        logic        valid;
        logic        sof;
        logic        eof;
        logic        ferr;
        logic [15:0] data;
        int          s;
        int          e;
        int          f;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // present one word, let it be clocked in, sample just after the edge
    task automatic word(input logic [15:0] d, input logic kl, input logic km, input logic clr);
        @(negedge clk);
        rx_if.i_rxd   = d;
        rx_if.i_rklsb = kl;
        rx_if.i_rkmsb = km;
        clear         = clr;
        @(posedge clk);
        #1;
        if (rx_if.o_data_valid) nvalid++;
        clear = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " valid"}, 32'(rx_if.o_data_valid), 32'd0);
        chk({tag, " sof"},   32'(rx_if.o_sof), 32'd0);
        chk({tag, " eof"},   32'(rx_if.o_eof), 32'd0);
        chk({tag, " ferr"},  32'(frame_err), 32'd0);
        chk({tag, " lock"},  32'(lock), 32'd0);
        chk({tag, " data"},  32'(rx_if.o_data), 32'd0);
        chk({tag, " fcnt"},  frame_cnt, 32'd0);
        chk({tag, " ecnt"},  err_cnt, 32'd0);
        chk({tag, " scnt"},  sync_cnt, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rx_if.i_rxd = 16'h0000; rx_if.i_rklsb = 1'b0; rx_if.i_rkmsb = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // C,C,SOF then the data words; bad_idx flips bit 0, trunc_idx sends a comma instead
    task automatic send_frame(input int bad_idx, input int trunc_idx, input logic clr_eof,
                              input logic exp_lock);
        logic [15:0] d;
        word(C_W, 1'b1, 1'b0, 1'b0);
        word(C_W, 1'b1, 1'b0, 1'b0);
        word(S_W, 1'b1, 1'b0, 1'b0);
        chk("frame sof", 32'(rx_if.o_sof), 32'd1);
        chk("frame sof no valid", 32'(rx_if.o_data_valid), 32'd0);
        for (int i = 0; i < DL; i++) begin
            if (i == trunc_idx) begin
                word(C_W, 1'b1, 1'b0, 1'b0);
                chk("trunc ferr", 32'(frame_err), 32'd1);
                chk("trunc lock", 32'(lock), 32'd0);
                chk("trunc eof", 32'(rx_if.o_eof), 32'd0);
                return;
            end
            d = {3'b000, 5'(i), 3'b000, 5'(i)};
            if (i == bad_idx) d = d ^ 16'h0001;
            word(d, 1'b0, 1'b0, clr_eof && (i == DL - 1));
            chk("frame valid", 32'(rx_if.o_data_valid), 32'd1);
            chk("frame data", 32'(rx_if.o_data), 32'(d));
            chk("frame eof", 32'(rx_if.o_eof), 32'(i == DL - 1));
            chk("frame ferr", 32'(frame_err), 32'(i == bad_idx));
            if (i == DL - 1) chk("eof lock", 32'(lock), 32'(exp_lock));
        end
    endtask

    initial begin
        // word-class corners from reset: hunt, sync, restart, mismatch, truncation, clear
        tbl[0]  = '{16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 0, 0};
        tbl[1]  = '{S_W,      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 0, 0};
        tbl[2]  = '{16'hBCBC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 0, 0};
        tbl[3]  = '{C_W,      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 0, 0};
        tbl[4]  = '{C_W,      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 0, 0, 0};
        tbl[5]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1, 0, 0};
        tbl[6]  = '{C_W,      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 0, 0};
        tbl[7]  = '{S_W,      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1, 0, 0};
        tbl[8]  = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 0, 0};
        tbl[9]  = '{16'h0101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 2, 0, 0};
        tbl[10] = '{C_W,      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 2, 0, 0};
        tbl[11] = '{S_W,      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 2, 0, 0};
        tbl[12] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 2, 0, 0};
        tbl[13] = '{S_W,      1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 3, 0, 0};
        tbl[14] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 3, 0, 0};
        tbl[15] = '{16'h0002, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0002, 3, 1, 0};
        tbl[16] = '{16'h0202, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0202, 3, 1, 0};
        tbl[17] = '{C_W,      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0202, 4, 1, 0};
        tbl[18] = '{C_W,      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0202, 0, 0, 0};
        tbl[19] = '{16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0202, 0, 0, 0};

        rst_n = 1'b0;
        clear = 1'b0;
        rx_if.i_rxd = 16'h0000; rx_if.i_rklsb = 1'b0; rx_if.i_rkmsb = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        for (int v = 0; v < 20; v++) begin
            word(tbl[v].rxd, tbl[v].kl, tbl[v].km, tbl[v].clr);
            chk($sformatf("vec%0d valid", v), 32'(rx_if.o_data_valid), 32'(tbl[v].valid));
            chk($sformatf("vec%0d sof", v),   32'(rx_if.o_sof), 32'(tbl[v].sof));
            chk($sformatf("vec%0d eof", v),   32'(rx_if.o_eof), 32'(tbl[v].eof));
            chk($sformatf("vec%0d ferr", v),  32'(frame_err), 32'(tbl[v].ferr));
            chk($sformatf("vec%0d data", v),  32'(rx_if.o_data), 32'(tbl[v].data));
            chk($sformatf("vec%0d scnt", v),  sync_cnt, 32'(tbl[v].s));
            chk($sformatf("vec%0d ecnt", v),  err_cnt, 32'(tbl[v].e));
            chk($sformatf("vec%0d fcnt", v),  frame_cnt, 32'(tbl[v].f));
        end

        // clean lock: five frames, lock at the fourth eof
        do_reset();
        nvalid = 0;
        send_frame(-1, -1, 1'b0, 1'b0);
        send_frame(-1, -1, 1'b0, 1'b0);
        send_frame(-1, -1, 1'b0, 1'b0);
        send_frame(-1, -1, 1'b0, 1'b1);
        send_frame(-1, -1, 1'b0, 1'b1);
        chk("lock fcnt", frame_cnt, 32'd5);
        chk("lock ecnt", err_cnt, 32'd0);
        chk("lock scnt", sync_cnt, 32'd0);
        chk("lock nvalid", 32'(nvalid), 32'd160);

        // data corruption at idx 7, then relock after four clean frames
        send_frame(7, -1, 1'b0, 1'b0);
        chk("corrupt ecnt", err_cnt, 32'd1);
        chk("corrupt fcnt", frame_cnt, 32'd5);
        send_frame(-1, -1, 1'b0, 1'b0);
        send_frame(-1, -1, 1'b0, 1'b0);
        send_frame(-1, -1, 1'b0, 1'b0);
        send_frame(-1, -1, 1'b0, 1'b1);
        chk("relock fcnt", frame_cnt, 32'd9);

        // truncation by a comma at idx 20, then a normal frame
        send_frame(-1, 20, 1'b0, 1'b0);
        chk("trunc scnt", sync_cnt, 32'd1);
        send_frame(-1, -1, 1'b0, 1'b0);
        chk("after trunc fcnt", frame_cnt, 32'd10);
        chk("after trunc scnt", sync_cnt, 32'd1);

        // hunt robustness: random data and an early SOF are ignored
        do_reset();
        for (int n = 0; n < 50; n++) begin
            word(16'($urandom), 1'b0, 1'b0, 1'b0);
            chk("hunt valid", 32'(rx_if.o_data_valid), 32'd0);
            chk("hunt ferr", 32'(frame_err), 32'd0);
        end
        word(S_W, 1'b1, 1'b0, 1'b0);
        chk("hunt sof ignored", 32'(rx_if.o_sof), 32'd0);
        chk("hunt scnt", sync_cnt, 32'd0);
        send_frame(-1, -1, 1'b0, 1'b0);
        chk("hunt fcnt", frame_cnt, 32'd1);
        chk("hunt scnt after", sync_cnt, 32'd0);

        // clear coincident with a clean eof increment
        send_frame(-1, -1, 1'b1, 1'b0);
        chk("clear fcnt", frame_cnt, 32'd0);

        // saturation of the mismatch counter
        word(C_W, 1'b1, 1'b0, 1'b0);
        force dut.err_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.err_cnt_q;
        send_frame(3, -1, 1'b0, 1'b0);
        chk("sat ecnt first", err_cnt, 32'hFFFF_FFFF);
        send_frame(5, -1, 1'b0, 1'b0);
        chk("sat ecnt hold", err_cnt, 32'hFFFF_FFFF);

        // async reset mid-frame at idx 10
        word(C_W, 1'b1, 1'b0, 1'b0);
        word(S_W, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            word({3'b000, 5'(i), 3'b000, 5'(i)}, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_zero("async rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 10; i < 16; i++) begin
            word({3'b000, 5'(i), 3'b000, 5'(i)}, 1'b0, 1'b0, 1'b0);
            chk("post rst valid", 32'(rx_if.o_data_valid), 32'd0);
        end
        word(S_W, 1'b1, 1'b0, 1'b0);
        chk("post rst sof", 32'(rx_if.o_sof), 32'd0);
        chk("post rst scnt", sync_cnt, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
